// File: rtl/freq_timer_bank_pkg.sv
// ---------------------------------------------------------------------------
// freq_timer_bank_pkg
//   Shared timer constants and types for the frequency timer bank. The
//   sound-channel blocks import the same package, so they use the same
//   default counter width and prescale ratio.
//
//   Contents:
//     FTB_NUM_CH_DEF    default number of timer channels
//     FTB_WIDTH_DEF     default counter / freq register width
//     FTB_PRESCALE_DEF  default shared prescaler divide ratio
//     ch_state_e        per-channel run state
//     presc_width()     bit width needed for a 0..PRESCALE-1 counter
// ---------------------------------------------------------------------------
package freq_timer_bank_pkg;

    localparam int FTB_NUM_CH_DEF   = 4;
    localparam int FTB_WIDTH_DEF    = 11;
    localparam int FTB_PRESCALE_DEF = 4;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_e;

    // A divide ratio of 1 still needs a 1-bit counter. That counter simply
    // stays at zero.
    function automatic int presc_width(input int p);
        return (p > 1) ? $clog2(p) : 1;
    endfunction

endpackage : freq_timer_bank_pkg

// File: rtl/freq_timer_bank_if.sv
// ---------------------------------------------------------------------------
// freq_timer_bank_if
//   Control and status bundle between a sound-channel controller (master)
//   and the frequency timer bank (slave).
//
//   Signals (all NUM_CH wide unless noted):
//     en       master->slave  per-channel enable (level)
//     trig     master->slave  per-channel restart strobe, one clk wide
//     oneshot  master->slave  1 = stop after first expiry, 0 = periodic
//     freq     master->slave  NUM_CH*WIDTH reload values, ch i at [i*WIDTH +: WIDTH]
//     tick     slave->master  one-clk pulse per expiry
//     active   slave->master  channel running
//     count    slave->master  NUM_CH*WIDTH counter readback
// ---------------------------------------------------------------------------
interface freq_timer_bank_if
    import freq_timer_bank_pkg::*;
#(
    parameter int NUM_CH = FTB_NUM_CH_DEF,
    parameter int WIDTH  = FTB_WIDTH_DEF
);

    logic [NUM_CH-1:0]       en;
    logic [NUM_CH-1:0]       trig;
    logic [NUM_CH-1:0]       oneshot;
    logic [NUM_CH*WIDTH-1:0] freq;
    logic [NUM_CH-1:0]       tick;
    logic [NUM_CH-1:0]       active;
    logic [NUM_CH*WIDTH-1:0] count;

    modport master (
        output en,
        output trig,
        output oneshot,
        output freq,
        input  tick,
        input  active,
        input  count
    );

    modport slave (
        input  en,
        input  trig,
        input  oneshot,
        input  freq,
        output tick,
        output active,
        output count
    );

endinterface : freq_timer_bank_if

// File: rtl/freq_timer_channel.sv
// ---------------------------------------------------------------------------
// freq_timer_channel
//   One up-counting frequency timer. On each shared prescaler strobe the
//   counter advances by one. When a strobe arrives with the counter at
//   all-ones, the channel expires: it reloads from i_freq and pulses o_tick.
//   The period is therefore 2^WIDTH - freq strobes.
//
//   Ports:
//     clk        system clock
//     rst_n      asynchronous active-low reset
//     i_stb      shared prescaler strobe
//     i_en       enable (level); 0 stops the channel and freezes the count
//     i_trig     restart strobe; loads freq and starts the channel
//     i_oneshot  1 = return to idle on expiry
//     i_freq     reload value
//     o_tick     registered one-clk expiry pulse
//     o_active   channel running
//     o_count    current counter value
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   CH_IDLE | stopped; count holds its last value; waits for trig with en=1
//   CH_RUN  | counting on strobes; reloads and ticks at all-ones
// ---------------------------------------------------------------------------
module freq_timer_channel
    import freq_timer_bank_pkg::*;
#(
    parameter int WIDTH = FTB_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_stb,
    input  logic             i_en,
    input  logic             i_trig,
    input  logic             i_oneshot,
    input  logic [WIDTH-1:0] i_freq,
    output logic             o_tick,
    output logic             o_active,
    output logic [WIDTH-1:0] o_count
);

    ch_state_e        r_state;
    ch_state_e        w_state_nxt;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic             r_tick;
    logic             w_tick_nxt;
    logic             w_expire;

    assign w_expire = (r_state == CH_RUN) && i_stb && (r_count == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CH_IDLE;
            r_count <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_tick  <= w_tick_nxt;
        end
    end

    // The order of the branches sets the priority: disable, then restart,
    // then expiry, then count. A trig on the same edge as an expiry
    // therefore suppresses that tick.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_tick_nxt  = 1'b0;
        if (!i_en) begin
            w_state_nxt = CH_IDLE;
        end else if (i_trig) begin
            w_state_nxt = CH_RUN;
            w_count_nxt = i_freq;
        end else if (w_expire) begin
            // freq and oneshot are sampled here, so changes made during a
            // period do not disturb that period.
            w_tick_nxt  = 1'b1;
            w_count_nxt = i_freq;
            if (i_oneshot) begin
                w_state_nxt = CH_IDLE;
            end
        end else if ((r_state == CH_RUN) && i_stb) begin
            w_count_nxt = r_count + WIDTH'(1);
        end
    end

    assign o_tick   = r_tick;
    assign o_active = (r_state == CH_RUN);
    assign o_count  = r_count;

endmodule : freq_timer_channel

// File: rtl/freq_timer_bank.sv
// ---------------------------------------------------------------------------
// freq_timer_bank
//   NUM_CH independent frequency timers driven by one shared prescaler.
//   The prescaler runs freely from 0 to PRESCALE-1 and strobes every channel
//   in the cycle where it reaches PRESCALE-1. A trig does not reset the
//   prescaler, so the first period after a trig can be up to PRESCALE-1
//   clks short.
//
//   Parameters:
//     NUM_CH    number of timer channels
//     WIDTH     counter / freq width
//     PRESCALE  shared prescaler divide ratio (>= 1)
//
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     bus    slave side of freq_timer_bank_if (en/trig/oneshot/freq in,
//            tick/active/count out)
// ---------------------------------------------------------------------------
module freq_timer_bank
    import freq_timer_bank_pkg::*;
#(
    parameter int NUM_CH   = FTB_NUM_CH_DEF,
    parameter int WIDTH    = FTB_WIDTH_DEF,
    parameter int PRESCALE = FTB_PRESCALE_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    freq_timer_bank_if.slave   bus
);

    localparam int            PW   = presc_width(PRESCALE);
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    logic [PW-1:0]           r_presc;
    logic                    w_stb;
    logic [NUM_CH-1:0]       w_tick;
    logic [NUM_CH-1:0]       w_active;
    logic [NUM_CH*WIDTH-1:0] w_count;

    assign w_stb = (r_presc == PMAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (w_stb) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        freq_timer_channel #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_stb     (w_stb),
            .i_en      (bus.en[i]),
            .i_trig    (bus.trig[i]),
            .i_oneshot (bus.oneshot[i]),
            .i_freq    (bus.freq[i*WIDTH +: WIDTH]),
            .o_tick    (w_tick[i]),
            .o_active  (w_active[i]),
            .o_count   (w_count[i*WIDTH +: WIDTH])
        );
    end

    assign bus.tick   = w_tick;
    assign bus.active = w_active;
    assign bus.count  = w_count;

endmodule : freq_timer_bank

// File: tb/tb_freq_timer_bank.sv
// ---------------------------------------------------------------------------
// tb_freq_timer_bank
//   Directed bench. u_dut_a: 4 channels, WIDTH=3, PRESCALE=1.
//   u_dut_b: 1 channel, WIDTH=3, PRESCALE=4.
// ---------------------------------------------------------------------------
module tb_freq_timer_bank;

    localparam int W = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    freq_timer_bank_if #(.NUM_CH(4), .WIDTH(W)) bus_a ();
    freq_timer_bank_if #(.NUM_CH(1), .WIDTH(W)) bus_b ();

    freq_timer_bank #(.NUM_CH(4), .WIDTH(W), .PRESCALE(1)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    freq_timer_bank #(.NUM_CH(1), .WIDTH(W), .PRESCALE(4)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    int n_err = 0;
    int n_chk = 0;

    // Bench-side edge counter since reset release. For PRESCALE=4, edge n
    // carries a strobe when n % 4 == 0.
    int ecount;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ecount <= 0;
        else        ecount <= ecount + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int cnt_a(input int ch);
        return int'(bus_a.count[ch*W +: W]);
    endfunction

    task automatic set_freq_a(input int ch, input int f);
        bus_a.freq[ch*W +: W] = W'(f);
    endtask

    // Advance one edge, then check ch0 of u_dut_a.
    task automatic expect_a0(input string tag, input int tk, input int c, input int act);
        step();
        check({tag, "_tick"},   int'(bus_a.tick[0]),   tk);
        check({tag, "_count"},  cnt_a(0),              c);
        check({tag, "_active"}, int'(bus_a.active[0]), act);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_c [9] = '{6, 7, 5, 6, 7, 5, 6, 7, 5};
        int exp_t [9] = '{0, 0, 1, 0, 0, 1, 0, 0, 1};
        int nt0, nt1, gap;
        bit found;

        bus_a.en = '0; bus_a.trig = '0; bus_a.oneshot = '0; bus_a.freq = '0;
        bus_b.en = '0; bus_b.trig = '0; bus_b.oneshot = '0; bus_b.freq = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int ch = 0; ch < 4; ch++) begin
            check($sformatf("rst_count%0d", ch),  cnt_a(ch),               0);
            check($sformatf("rst_active%0d", ch), int'(bus_a.active[ch]), 0);
            check($sformatf("rst_tick%0d", ch),   int'(bus_a.tick[ch]),   0);
        end

        // ---- periodic, freq=5 -> 5,6,7,5,... period 3
        bus_a.en[0] = 1'b1;
        set_freq_a(0, 5);
        bus_a.trig[0] = 1'b1;
        expect_a0("per_trig", 0, 5, 1);
        bus_a.trig[0] = 1'b0;
        for (int i = 0; i < 9; i++) begin
            expect_a0($sformatf("per%0d", i), exp_t[i], exp_c[i], 1);
        end

        // ---- asynchronous reset mid-operation
        step();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_count",  cnt_a(0),              0);
        check("arst_active", int'(bus_a.active[0]), 0);
        check("arst_tick",   int'(bus_a.tick[0]),   0);
        repeat (3) step();
        check("arst_hold_count",  cnt_a(0),              0);
        check("arst_hold_active", int'(bus_a.active[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step();
        check("arst_norestart_active", int'(bus_a.active[0]), 0);
        check("arst_norestart_count",  cnt_a(0),              0);

        // ---- oneshot, freq=6: tick 2 edges after trig
        bus_a.oneshot[0] = 1'b1;
        set_freq_a(0, 6);
        bus_a.trig[0] = 1'b1;
        expect_a0("os_trig", 0, 6, 1);
        bus_a.trig[0] = 1'b0;
        expect_a0("os_e1", 0, 7, 1);
        expect_a0("os_e2", 1, 6, 0);
        nt0 = 0;
        repeat (20) begin
            step();
            nt0 += int'(bus_a.tick[0]);
        end
        check("os_quiet_ticks",  nt0,                  0);
        check("os_quiet_active", int'(bus_a.active[0]), 0);
        check("os_quiet_count",  cnt_a(0),              6);
        bus_a.trig[0] = 1'b1;
        step();
        bus_a.trig[0] = 1'b0;
        nt0 = 0;
        repeat (6) begin
            step();
            nt0 += int'(bus_a.tick[0]);
        end
        check("os_retrig_ticks",  nt0,                  1);
        check("os_retrig_active", int'(bus_a.active[0]), 0);

        // ---- trig coincident with expiry, then a mid-period freq change
        bus_a.oneshot[0] = 1'b0;
        set_freq_a(0, 5);
        bus_a.trig[0] = 1'b1;
        expect_a0("co_start", 0, 5, 1);
        bus_a.trig[0] = 1'b0;
        expect_a0("co_e1", 0, 6, 1);
        expect_a0("co_e2", 0, 7, 1);
        set_freq_a(0, 4);
        bus_a.trig[0] = 1'b1;
        expect_a0("co_trig", 0, 4, 1);
        bus_a.trig[0] = 1'b0;
        expect_a0("co_e4", 0, 5, 1);
        set_freq_a(0, 6);
        expect_a0("co_e5", 0, 6, 1);
        expect_a0("co_e6", 0, 7, 1);
        expect_a0("co_reload", 1, 6, 1);
        expect_a0("co_e8", 0, 7, 1);
        expect_a0("co_e9", 1, 6, 1);

        // ---- two channels, freq 4 and 6 -> periods 4 and 2
        set_freq_a(0, 4);
        set_freq_a(1, 6);
        bus_a.en[1:0]   = 2'b11;
        bus_a.trig[1:0] = 2'b11;
        step();
        bus_a.trig[1:0] = 2'b00;
        nt0 = 0; nt1 = 0;
        repeat (12) begin
            step();
            nt0 += int'(bus_a.tick[0]);
            nt1 += int'(bus_a.tick[1]);
        end
        check("mc_ticks0", nt0,      3);
        check("mc_ticks1", nt1,      6);
        check("mc_count0", cnt_a(0), 4);
        check("mc_count1", cnt_a(1), 6);
        check("mc_idle2_active", int'(bus_a.active[2]), 0);
        check("mc_idle2_count",  cnt_a(2),              0);
        bus_a.en[1] = 1'b0;
        step();
        check("mc_dis_active1", int'(bus_a.active[1]), 0);
        check("mc_dis_count1",  cnt_a(1),              6);
        check("mc_dis_count0",  cnt_a(0),              5);
        set_freq_a(1, 2);
        bus_a.trig[1] = 1'b1;
        step();
        bus_a.trig[1] = 1'b0;
        check("mc_trigoff_active1", int'(bus_a.active[1]), 0);
        check("mc_trigoff_count1",  cnt_a(1),              6);
        nt0 = 0; nt1 = 0;
        repeat (6) begin
            step();
            nt0 += int'(bus_a.tick[0]);
            nt1 += int'(bus_a.tick[1]);
        end
        check("mc_after_ticks0", nt0,      2);
        check("mc_after_ticks1", nt1,      0);
        check("mc_after_count1", cnt_a(1), 6);

        // ---- PRESCALE=4, freq=7 -> tick after every strobe edge
        bus_b.en[0]   = 1'b1;
        bus_b.freq    = W'(7);
        bus_b.trig[0] = 1'b1;
        step();
        bus_b.trig[0] = 1'b0;
        check("ps_trig_count", int'(bus_b.count), 7);
        for (int i = 0; i < 16; i++) begin
            step();
            check($sformatf("ps_tick_e%0d", ecount), int'(bus_b.tick[0]),
                  ((ecount % 4) == 0) ? 1 : 0);
        end
        bus_b.freq = W'(0);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            step();
            if (bus_b.tick[0]) found = 1'b1;
        end
        check("ps_f0_reload_seen",  int'(found),       1);
        check("ps_f0_reload_count", int'(bus_b.count), 0);
        gap = -1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (bus_b.tick[0]) begin
                gap = i;
                break;
            end
        end
        check("ps_f0_period", gap, 32);
        check("ps_f0_align",  ecount % 4, 0);
        check("ps_active",    int'(bus_b.active[0]), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_freq_timer_bank

// File: doc/freq_timer_bank.md
Name: freq_timer_bank

Overview:
Bank of NUM_CH independent programmable frequency timers for the sound channels. It replaces single-channel variable dividers with Game Boy-style up-counting frequency timers that reload from a per-channel freq register. A shared prescaler drives all channels. Each channel has enable, trigger/restart, periodic or one-shot mode, and a one-cycle tick output that clocks the downstream waveform/duty stepping logic.

Parameters:
NUM_CH, 4, number of timer channels
WIDTH, 11, counter/freq width; period = 2^WIDTH - freq prescaler strobes
PRESCALE, 4, shared prescaler divide ratio (>=1); 1 = strobe every clk

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
en  input  NUM_CH  per-channel enable (level)
trig  input  NUM_CH  per-channel restart strobe, one clk wide
oneshot  input  NUM_CH  1 = stop after first expiry, 0 = periodic
freq  input  NUM_CH*WIDTH  per-channel reload value, channel i at [i*WIDTH +: WIDTH]
tick  output  NUM_CH  one-clk pulse per expiry
active  output  NUM_CH  channel running
count  output  NUM_CH*WIDTH  current counter value (debug/readback)

Behaviour:
- Reset (rst_n=0, async, also mid-operation): prescaler=0, all count=0, active=0, tick=0; held until rst_n rises.
- Prescaler: free-running 0..PRESCALE-1, wraps. Internal strobe stb is high in the cycle where prescaler==PRESCALE-1. Trig does not reset it, so the first period after trig may be up to PRESCALE-1 clks short.
- Per channel i, priority order at each rising edge:
  1. en[i]=0: active<=0, count holds, tick<=0. Trig is ignored.
  2. trig[i]=1 (en=1): count<=freq[i], active<=1, tick<=0. Trig beats a coincident expiry, so no tick. Trig while active restarts the channel.
  3. active && stb && count==all-ones (expiry): tick<=1, count<=freq[i] (freq sampled at reload). If oneshot[i], active<=0 on the same edge.
  4. active && stb, not expiry: count<=count+1 (WIDTH-bit), tick<=0.
  5. Otherwise: hold, tick<=0.
- Tick and active are registered. Tick is high for exactly one clk, in the cycle after the expiry edge.
- Period: 2^WIDTH - freq strobes. freq=all-ones gives a tick every strobe. freq=0 gives the maximum period, 2^WIDTH strobes. Count never exceeds all-ones, and no wrap beyond reload.
- A freq change while counting takes effect at the next reload or trig only. The current period is not disturbed.
- oneshot change mid-period is sampled at expiry.
- When inactive, count holds its last value (readback stays stable).
- Channels are fully independent except for the shared stb.

Decomposition:
- Shared header of timer constants (default WIDTH, default PRESCALE), included by this block and the sound-channel blocks.
- One sub-module, freq_timer_channel (params WIDTH): holds count, active, tick and the priority logic. It is instantiated NUM_CH times in a generate loop.
- The prescaler stays inline in freq_timer_bank.

Test Plan:
1. Reset: run ch0 periodic, then drop rst_n between clk edges -> tick, active, count all 0 immediately. They stay 0 until rst_n=1, and nothing restarts without a new trig.
2. WIDTH=3, PRESCALE=1, ch0 freq=5 periodic, trig at edge k -> count 5,6,7,5,... Tick is high in the cycles after edges k+3, k+6, k+9 (period 3). Active stays 1.
3. WIDTH=3, PRESCALE=4, freq=7 -> one tick every 4 clks, aligned to prescaler wrap. Then freq=0 -> after the next reload, period is 8 strobes = 32 clks.
4. Oneshot, WIDTH=3, PRESCALE=1, freq=6 -> exactly one tick, 2 edges after trig. Active falls on the tick edge, and there are no further ticks for 20 clks. A re-trig produces one more tick.
5. Trig asserted on the same edge as an expiry (count=7, stb=1) -> no tick, count=freq. The next tick arrives a full period later.
6. WIDTH=3, PRESCALE=1: ch0 freq=4, ch1 freq=6 -> tick periods of 4 and 2 clks with no cross-talk. Drop en[1] -> active[1]=0 and count[1] frozen while ch0 continues. Trig[1] while en[1]=0 is ignored.
